hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline hazard and control unit for the 24-bit, 5-stage core (F, D, E, M, W).
- Drives the stall enables and clear (clr) inputs of the F/D, D/E and M/W pipeline registers.
- Selects the E-stage operand forwarding muxes.
- Holds the whole pipeline while the M-stage data memory has not completed an access, with timeout detection.

Parameters:
- N, 24, datapath width (used only by the optional perf counters)
- MEM_TIMEOUT, 16, maximum wait cycles for a memory access before error
- CNT_W, 5, width of the wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- RA1D, RA2D  in  4  D-stage source register addresses
- RA1E, RA2E  in  4  E-stage source register addresses
- A3E, A3M, A3W  in  4  destination register addresses in E/M/W
- RegWriteM, RegWriteW  in  1  write-back enables in M/W
- MemtoRegE  in  1  E-stage instruction is a load
- BranchTakenE  in  1  taken branch/PC write resolved in E
- MemReqM  in  1  M-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the PC / F-D / D-E / E-M registers
- FlushD, FlushE, FlushW  out  1  clr of the F-D / D-E / M-W registers
- ForwardAE, ForwardBE  out  2  operand source: 00 register file, 01 W result, 10 M ALU result
- MemErr  out  1  sticky memory timeout flag
- HzState  out  2  current FSM state (debug)

Behaviour:
- Reset: while rst=0 at a clock edge, the state goes to RUN, the wait counter and MemErr clear.
- While rst=0, outputs are forced combinationally:
  - all Stall* = 0
  - FlushD = FlushE = FlushW = 1
  - ForwardAE = ForwardBE = 00
  - HzState = 00
- Forwarding (combinational, all states), for each operand X in {A,B} with source RAxE:
  - 10 if RegWriteM && A3M==RAxE
  - else 01 if RegWriteW && A3W==RAxE
  - else 00
  - M has priority over W.
- FSM states: RUN=00, MEM_WAIT=01, MEM_ERR=10. Outputs are Mealy, same-cycle, with zero added latency.
- RUN:
  - If MemReqM && !MemReadyM: assert StallF/D/E/M and FlushW; go to MEM_WAIT; counter <= 1.
  - Else if BranchTakenE: FlushD=1, FlushE=1, no stalls. A branch overrides load-use.
  - Else if MemtoRegE && (RA1D==A3E || RA2D==A3E): load-use. StallF=1, StallD=1, FlushE=1 for exactly one cycle. The next cycle re-evaluates normally.
  - Else all stall/flush outputs = 0.
- MEM_WAIT:
  - StallF/D/E/M=1 and FlushW=1 every cycle; the counter increments.
  - BranchTakenE and load-use are ignored because E is frozen.
  - If MemReadyM: release the same cycle (stalls 0, FlushW 0); go to RUN; counter <= 0.
  - Else if counter == MEM_TIMEOUT: set MemErr; go to MEM_ERR; stalls released this cycle.
- MEM_ERR:
  - Behaves as RUN for hazard decisions, but never re-enters MEM_WAIT. The access is abandoned and the pipeline proceeds.
  - MemErr stays 1 until reset.
- Counter saturates and never wraps.
- Register-address compares are full 4-bit equality with no special register.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- With the macro defined, add outputs:
  - StallCount [N-1:0]: increments on every cycle with StallF=1
  - FlushCount [N-1:0]: increments on every cycle with FlushE=1 caused by a branch
- Both counters saturate at all-ones and reset to 0.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg contains:
  - typedef enum logic [1:0] hz_state_t {RUN, MEM_WAIT, MEM_ERR}
  - typedef enum logic [1:0] fwd_sel_t {FWD_RF=00, FWD_W=01, FWD_M=10}
  - localparam REG_ADDR_W=4
- One natural sub-module: forward_unit, the combinational forwarding selector, instantiated once per operand.

Test Plan:
- RA1E=3, A3M=3, RegWriteM=1, A3W=3, RegWriteW=1 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01; RA2E=5 with no match -> ForwardBE=00.
- MemtoRegE=1, A3E=2, RA2D=2 -> StallF=StallD=FlushE=1 for one cycle; MemtoRegE=0 on the next cycle -> all deasserted.
- BranchTakenE=1 together with a load-use match -> FlushD=FlushE=1, StallF=StallD=0.
- MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..M=1 and FlushW=1 for 3 cycles, all 0 on the ready cycle, HzState 01 then 00, MemErr=0.
- MemReqM=1, MemReadyM held 0 with MEM_TIMEOUT=16 -> MemErr=1 after 16 wait cycles, HzState=10, stalls released; a later MemReqM with !MemReadyM causes no stall; rst=0 clears MemErr.
- rst=0 asserted mid MEM_WAIT -> next cycle HzState=00, stalls 0, counter 0; while rst=0, FlushD/E/W=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_ERR  = 2'b10
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Combinational E-stage operand forwarding selector for one source operand.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ra_e_i,
  input  logic [REG_ADDR_W-1:0] a3_m_i,
  input  logic [REG_ADDR_W-1:0] a3_w_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  output logic [1:0]            fwd_sel_o
);

  fwd_sel_t sel;

  // The M-stage result is younger than the W-stage one, so it wins a double match.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m_i && (a3_m_i == ra_e_i)) begin
      sel = FWD_M;
    end else if (reg_write_w_i && (a3_w_i == ra_e_i)) begin
      sel = FWD_W;
    end
  end

  assign fwd_sel_o = sel;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard/control unit: stalls, flushes, forwarding and memory-wait FSM.
// Optional macro HAZARD_PERF_EN adds saturating stall/branch-flush counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int N           = 24,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] RA1E,
  input  logic [REG_ADDR_W-1:0] RA2E,
  input  logic [REG_ADDR_W-1:0] A3E,
  input  logic [REG_ADDR_W-1:0] A3M,
  input  logic [REG_ADDR_W-1:0] A3W,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  BranchTakenE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MemErr,
  output logic [1:0]            HzState
`ifdef HAZARD_PERF_EN
  ,
  output logic [N-1:0]          StallCount,
  output logic [N-1:0]          FlushCount
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  generate
    if ((2 ** CNT_W) <= MEM_TIMEOUT || N < 1) begin : g_bad_params
      $error("hazard_controller: CNT_W too narrow for MEM_TIMEOUT, or N < 1");
    end
  endgenerate

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic br_flush;
  logic load_use;
  logic [1:0] fwd_a, fwd_b;

  forward_unit u_fwd_a (
    .ra_e_i        (RA1E),
    .a3_m_i        (A3M),
    .a3_w_i        (A3W),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_sel_o     (fwd_a)
  );

  forward_unit u_fwd_b (
    .ra_e_i        (RA2E),
    .a3_m_i        (A3M),
    .a3_w_i        (A3W),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_sel_o     (fwd_b)
  );

  assign load_use = MemtoRegE && ((RA1D == A3E) || (RA2D == A3E));

  // Mealy decode: outputs follow the current state and this cycle's inputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    br_flush = 1'b0;
    case (state_q)
      RUN, MEM_ERR: begin
        // After a timeout the access is abandoned, so MEM_ERR never waits again.
        if ((state_q == RUN) && MemReqM && !MemReadyM) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (BranchTakenE) begin
          flush_d  = 1'b1;
          flush_e  = 1'b1;
          br_flush = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_C) begin
          err_d   = 1'b1;
          state_d = MEM_ERR;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset holds the pipeline registers cleared and releases every stall.
  assign StallF    = rst & stall_f;
  assign StallD    = rst & stall_d;
  assign StallE    = rst & stall_e;
  assign StallM    = rst & stall_m;
  assign FlushD    = !rst | flush_d;
  assign FlushE    = !rst | flush_e;
  assign FlushW    = !rst | flush_w;
  assign ForwardAE = rst ? fwd_a : 2'b00;
  assign ForwardBE = rst ? fwd_b : 2'b00;
  assign HzState   = rst ? state_q : 2'b00;
  assign MemErr    = err_q;

`ifdef HAZARD_PERF_EN
  logic [N-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + N'(1);
      if (br_flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + N'(1);
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table plus multi-cycle sequences.
module tb_hazard_controller;

  localparam int OW = 14;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, A3E, A3M, A3W;
  logic RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE, HzState;
`ifdef HAZARD_PERF_EN
  logic [23:0] StallCount, FlushCount;
`endif

  hazard_controller dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .A3E(A3E), .A3M(A3M), .A3W(A3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .HzState(HzState)
`ifdef HAZARD_PERF_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, a3e, a3m, a3w;
    logic     rwm, rww, mtr, br, mreq, mrdy;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t tv[13];

  // scoreboard
  logic [OW-1:0] exp_q[$];
  string         name_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [OW-1:0] ex(input logic [3:0] stl, input logic [2:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic err, input logic [1:0] st);
    return {stl, fl, fa, fb, err, st};
  endfunction

  function automatic vec_t mkv(input string nm,
                               input logic [3:0] ra1d, ra2d, ra1e, ra2e, a3e, a3m, a3w,
                               input logic rwm, rww, mtr, br, mreq, mrdy,
                               input logic [OW-1:0] exp);
    vec_t v;
    v.name = nm; v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
    v.a3e = a3e; v.a3m = a3m; v.a3w = a3w; v.rwm = rwm; v.rww = rww;
    v.mtr = mtr; v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
    return v;
  endfunction

  // driver tasks
  task automatic idle();
    RA1D = 4'd1; RA2D = 4'd2; RA1E = 4'd13; RA2E = 4'd14;
    A3E = 4'd10; A3M = 4'd11; A3W = 4'd12;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
    A3E = v.a3e; A3M = v.a3m; A3W = v.a3w;
    RegWriteM = v.rwm; RegWriteW = v.rww; MemtoRegE = v.mtr;
    BranchTakenE = v.br; MemReqM = v.mreq; MemReadyM = v.mrdy;
  endtask

  // Inputs are driven just after a falling edge; outputs are sampled 2ns later.
  task automatic apply(input string nm, input logic [OW-1:0] exp);
    logic [OW-1:0] act, e;
    string n;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    #2;
    act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, HzState};
    e = exp_q.pop_front();
    n = name_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (stlFDEM_flDEW_fa_fb_err_st)", n, act, e);
    end
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = mkv("fwd_m_prio", 1, 2, 3, 5, 10, 3, 3, 1, 1, 0, 0, 0, 0, ex(4'b0, 3'b0, 2'b10, 2'b00, 0, 2'b00));
    tv[1]  = mkv("fwd_w",      1, 2, 3, 5, 10, 3, 3, 0, 1, 0, 0, 0, 0, ex(4'b0, 3'b0, 2'b01, 2'b00, 0, 2'b00));
    tv[2]  = mkv("fwd_none",   1, 2, 3, 5, 10, 3, 3, 0, 0, 0, 0, 0, 0, ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b00));
    tv[3]  = mkv("fwd_mixed",  1, 2, 9, 7, 10, 7, 9, 1, 1, 0, 0, 0, 0, ex(4'b0, 3'b0, 2'b01, 2'b10, 0, 2'b00));
    tv[4]  = mkv("fwd_both_m", 1, 2, 6, 6, 10, 6, 12, 1, 0, 0, 0, 0, 0, ex(4'b0, 3'b0, 2'b10, 2'b10, 0, 2'b00));
    tv[5]  = mkv("fwd_r0_w",   1, 2, 0, 0, 10, 11, 0, 0, 1, 0, 0, 0, 0, ex(4'b0, 3'b0, 2'b01, 2'b01, 0, 2'b00));
    tv[6]  = mkv("lu_ra2",     1, 2, 13, 14, 2, 11, 12, 0, 0, 1, 0, 0, 0, ex(4'b1100, 3'b010, 2'b00, 2'b00, 0, 2'b00));
    tv[7]  = mkv("lu_release", 1, 2, 13, 14, 2, 11, 12, 0, 0, 0, 0, 0, 0, ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b00));
    tv[8]  = mkv("lu_ra1",     4, 2, 13, 14, 4, 11, 12, 0, 0, 1, 0, 0, 0, ex(4'b1100, 3'b010, 2'b00, 2'b00, 0, 2'b00));
    tv[9]  = mkv("lu_nomatch", 1, 2, 13, 14, 4, 11, 12, 0, 0, 1, 0, 0, 0, ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b00));
    tv[10] = mkv("br_over_lu", 1, 2, 13, 14, 2, 11, 12, 0, 0, 1, 1, 0, 0, ex(4'b0, 3'b110, 2'b00, 2'b00, 0, 2'b00));
    tv[11] = mkv("br_only",    1, 2, 13, 14, 10, 11, 12, 0, 0, 0, 1, 0, 0, ex(4'b0, 3'b110, 2'b00, 2'b00, 0, 2'b00));
    tv[12] = mkv("mem_hit",    1, 2, 13, 14, 10, 11, 12, 0, 0, 0, 0, 1, 1, ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b00));

    rst = 1'b0;
    idle();
    RA1E = 4'd3; A3M = 4'd3; RegWriteM = 1'b1;
    @(negedge clk);
    apply("reset_forced", ex(4'b0, 3'b111, 2'b00, 2'b00, 0, 2'b00));
    rst = 1'b1;
    idle();
    apply("post_reset_idle", ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b00));

    for (int i = 0; i < 13; i++) begin
      drive_vec(tv[i]);
      apply(tv[i].name, tv[i].exp);
    end

    // Memory wait: three stalled cycles, then release on ready.
    idle();
    MemReqM = 1'b1;
    apply("mw_enter", ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2'b00));
    BranchTakenE = 1'b1; MemtoRegE = 1'b1; A3E = 4'd2;
    apply("mw_hold_br_ignored", ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2'b01));
    BranchTakenE = 1'b0; MemtoRegE = 1'b0; A3E = 4'd10;
    apply("mw_hold", ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2'b01));
    MemReadyM = 1'b1;
    apply("mw_release", ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b01));
    idle();
    apply("mw_back_run", ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b00));

    // Timeout: entry cycle plus 15 counted waits stall, the 16th releases.
    MemReqM = 1'b1;
    apply("to_enter", ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2'b00));
    for (int i = 1; i < 16; i++) begin
      apply($sformatf("to_wait_%0d", i), ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2'b01));
    end
    apply("to_expire", ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b01));
    apply("err_no_rewait", ex(4'b0, 3'b0, 2'b00, 2'b00, 1, 2'b10));
    MemReqM = 1'b0; BranchTakenE = 1'b1;
    apply("err_branch", ex(4'b0, 3'b110, 2'b00, 2'b00, 1, 2'b10));
    BranchTakenE = 1'b0; MemtoRegE = 1'b1; A3E = 4'd1;
    apply("err_load_use", ex(4'b1100, 3'b010, 2'b00, 2'b00, 1, 2'b10));
    idle();
    rst = 1'b0; RA2E = 4'd11; RegWriteM = 1'b1;
    apply("err_rst_forced", ex(4'b0, 3'b111, 2'b00, 2'b00, 1, 2'b00));
    apply("err_rst_cleared", ex(4'b0, 3'b111, 2'b00, 2'b00, 0, 2'b00));
    rst = 1'b1; idle();
    apply("err_after_rst", ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b00));

    // Reset in the middle of a memory wait.
    MemReqM = 1'b1;
    apply("mr_enter", ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2'b00));
    apply("mr_wait", ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2'b01));
    rst = 1'b0;
    apply("mr_rst_forced", ex(4'b0, 3'b111, 2'b00, 2'b00, 0, 2'b00));
    rst = 1'b1;
    apply("mr_run_again", ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2'b00));
    MemReadyM = 1'b1;
    apply("mr_release", ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b01));
    idle();
    apply("mr_idle", ex(4'b0, 3'b0, 2'b00, 2'b00, 0, 2'b00));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
